// File: rtl/alu_nibble_sequencer.sv
// 16-bit arithmetic built from one 4-bit arithmetic unit, evaluated serially one
// nibble per cycle (LSB first), with registered result, carry-out and zero flag.

module arithmetic_unit (
  input  logic [3:0] s,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out
);
  logic [3:0] x;
  logic [3:0] y;

  // Each function is x plus y plus c_in; "minus 1" forms add all-ones.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x = a;
    y = 4'h0;
    unique case (s)
      4'h0: begin x = a;        y = 4'h0;     end
      4'h1: begin x = a | b;    y = 4'h0;     end
      4'h2: begin x = a | ~b;   y = 4'h0;     end
      4'h3: begin x = 4'h0;     y = 4'hF;     end
      4'h4: begin x = a;        y = a & ~b;   end
      4'h5: begin x = a | b;    y = a & ~b;   end
      4'h6: begin x = a;        y = ~b;       end
      4'h7: begin x = a & ~b;   y = 4'hF;     end
      4'h8: begin x = a;        y = a & b;    end
      4'h9: begin x = a;        y = b;        end
      4'hA: begin x = a | ~b;   y = a & b;    end
      4'hB: begin x = a & b;    y = 4'hF;     end
      4'hC: begin x = a;        y = a;        end
      4'hD: begin x = a | b;    y = a;        end
      4'hE: begin x = a | ~b;   y = a;        end
      4'hF: begin x = a;        y = 4'hF;     end
      default: begin x = a;     y = 4'h0;     end
    endcase
    {c_out, f} = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
  end
endmodule

module alu_nibble_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  s,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] f,
  output logic        c_out,
  output logic        zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [3:0]  s_q;
  logic [15:0] a_q, b_q;
  logic [15:0] acc;
  logic        carry_q;
  logic [1:0]  idx;
  logic [3:0]  au_f;
  logic        au_c;
  logic [15:0] full_result;

  arithmetic_unit u_au (
    .s     (s_q),
    .a     (a_q[{idx, 2'b00} +: 4]),
    .b     (b_q[{idx, 2'b00} +: 4]),
    .c_in  (carry_q),
    .f     (au_f),
    .c_out (au_c)
  );

  // Top nibble comes straight from the unit; lower three were stored in earlier cycles.
  assign full_result = {au_f, acc[11:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: all datapath registers are reset; there is no array storage that would make this costly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= 4'h0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      acc     <= 16'h0000;
      carry_q <= 1'b0;
      idx     <= 2'd0;
      f       <= 16'h0000;
      c_out   <= 1'b0;
      zero    <= 1'b1;
    end else if (accept) begin
      s_q     <= s;
      a_q     <= a;
      b_q     <= b;
      carry_q <= c_in;
      idx     <= 2'd0;
    end else if (state == RUN) begin
      acc[{idx, 2'b00} +: 4] <= au_f;
      carry_q                <= au_c;
      idx                    <= idx + 2'd1;
      // Visible outputs update only on the final nibble, so they hold steady through RUN.
      if (idx == 2'd3) begin
        f     <= full_result;
        c_out <= au_c;
        zero  <= (full_result == 16'h0000);
      end
    end
  end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer: directed cases plus random operations
// compared against a whole-word arithmetic model of the 4-bit unit's function set.

module tb_alu_nibble_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  s;
  logic [15:0] a, b;
  logic        c_in;
  logic        busy, done, c_out, zero;
  logic [15:0] f;

  int errors = 0;
  int checks = 0;

  logic [15:0] cur_f;
  logic        cur_c;
  logic        cur_z;

  alu_nibble_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s     (s),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .f     (f),
    .c_out (c_out),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Whole-word reference: returns {carry_out, result} of the selected 16-bit operation.
  function automatic logic [16:0] model(input logic [3:0] fs, input logic [15:0] x,
                                        input logic [15:0] y, input logic ci);
    logic [16:0] one;
    logic [16:0] m1;
    one = {16'h0000, ci};
    m1  = 17'h0FFFF;
    case (fs)
      4'h0: model = {1'b0, x} + one;
      4'h1: model = {1'b0, x | y} + one;
      4'h2: model = {1'b0, x | ~y} + one;
      4'h3: model = m1 + one;
      4'h4: model = {1'b0, x} + {1'b0, x & ~y} + one;
      4'h5: model = {1'b0, x | y} + {1'b0, x & ~y} + one;
      4'h6: model = {1'b0, x} + {1'b0, ~y} + one;
      4'h7: model = {1'b0, x & ~y} + m1 + one;
      4'h8: model = {1'b0, x} + {1'b0, x & y} + one;
      4'h9: model = {1'b0, x} + {1'b0, y} + one;
      4'hA: model = {1'b0, x | ~y} + {1'b0, x & y} + one;
      4'hB: model = {1'b0, x & y} + m1 + one;
      4'hC: model = {1'b0, x} + {1'b0, x} + one;
      4'hD: model = {1'b0, x | y} + {1'b0, x} + one;
      4'hE: model = {1'b0, x | ~y} + {1'b0, x} + one;
      default: model = {1'b0, x} + m1 + one;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_run_cycle(input string tag);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " f_stable"}, {16'd0, f}, {16'd0, cur_f});
    check({tag, " c_stable"}, {31'd0, c_out}, {31'd0, cur_c});
  endtask

  task automatic check_done_cycle(input string tag, input logic [16:0] exp);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " f"}, {16'd0, f}, {16'd0, exp[15:0]});
    check({tag, " c_out"}, {31'd0, c_out}, {31'd0, exp[16]});
    check({tag, " zero"}, {31'd0, zero}, {31'd0, exp[15:0] == 16'h0000});
    cur_f = exp[15:0];
    cur_c = exp[16];
    cur_z = (exp[15:0] == 16'h0000);
  endtask

  // Called #1 after a rising edge with start low and the DUT idle or just done.
  task automatic run_op(input logic [3:0] fs, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input bit repulse, input string tag);
    logic [16:0] exp;
    exp   = model(fs, x, y, ci);
    s     = fs;
    a     = x;
    b     = y;
    c_in  = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    s     = 4'($urandom);
    a     = 16'($urandom);
    b     = 16'($urandom);
    c_in  = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      check_run_cycle(tag);
      start = (repulse && i == 1);
      tick();
    end
    start = 1'b0;
    check_done_cycle(tag, exp);
    tick();
    check({tag, " done_once"}, {31'd0, done}, 32'd0);
    check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [16:0] exp;
    rst   = 1'b1;
    start = 1'b0;
    s     = 4'h0;
    a     = 16'h0000;
    b     = 16'h0000;
    c_in  = 1'b0;
    cur_f = 16'h0000;
    cur_c = 1'b0;
    cur_z = 1'b1;

    // Start held high during reset must not be accepted.
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst f", {16'd0, f}, 32'd0);
    check("rst c_out", {31'd0, c_out}, 32'd0);
    check("rst zero", {31'd0, zero}, 32'd1);
    rst = 1'b0;

    // First edge with reset low accepts the start.
    run_op(4'b1001, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "add_1234");
    check("add_1234 literal", {16'd0, cur_f}, 32'h2233);
    run_op(4'b1001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
    run_op(4'b0110, 16'h0005, 16'h0003, 1'b1, 1'b0, "sub");
    run_op(4'b0000, 16'h00FF, 16'h1234, 1'b1, 1'b0, "inc");
    run_op(4'b1111, 16'h0000, 16'h5A5A, 1'b0, 1'b1, "dec_repulse");

    // Reset during the second RUN cycle aborts the operation.
    s     = 4'b1001;
    a     = 16'h0101;
    b     = 16'h0202;
    c_in  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    cur_f = 16'h0000;
    cur_c = 1'b0;
    cur_z = 1'b1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort f", {16'd0, f}, 32'd0);
    check("abort c_out", {31'd0, c_out}, 32'd0);
    check("abort zero", {31'd0, zero}, 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("abort no_done", {31'd0, done}, 32'd0);
      tick();
    end
    run_op(4'b1001, 16'h4321, 16'h1111, 1'b1, 1'b0, "after_abort");

    // Start held continuously: one result every five cycles.
    exp   = model(4'b1001, 16'h8F0F, 16'h1234, 1'b1);
    s     = 4'b1001;
    a     = 16'h8F0F;
    b     = 16'h1234;
    c_in  = 1'b1;
    start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        check_run_cycle("b2b");
        tick();
      end
      check_done_cycle("b2b", exp);
      if (k == 2) start = 1'b0;
      tick();
    end
    check("b2b stop busy", {31'd0, busy}, 32'd0);
    check("b2b stop done", {31'd0, done}, 32'd0);

    // Random operations across the full function set.
    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
